// File: rtl/ddr4_app_req_sequencer.sv
// ---------------------------------------------------------------------------------------------
// ddr4_app_req_sequencer
// Turns a simple valid/ready request stream into MIG (DDR4 UI) app-interface transactions.
// One request is in flight at a time. The command half (app_en/app_rdy) and the write-data half
// (app_wdf_wren/app_wdf_rdy) are handshaked independently. Read data is returned unthrottled
// one cycle after the MIG delivers it. Outstanding reads are counted and capped at MAX_RD.
//
// Ports:
//   ui_clk, ui_rst_n          clock, asynchronous active-low reset
//   init_calib_complete       MIG calibration done; gates new request acceptance only
//   req_*                     upstream request (valid/ready, wr, addr, wdata, byte enables)
//   app_en/cmd/addr/rdy       MIG command channel
//   app_wdf_*                 MIG write-data channel (mask is inverted byte enables)
//   app_rd_data*              MIG read-data channel
//   rsp_valid, rsp_data       registered read response
//   rd_outstanding            reads issued to the MIG whose data has not yet returned
//   err_rd_unexp              sticky: read data arrived with no read outstanding
// ---------------------------------------------------------------------------------------------
module ddr4_app_req_sequencer #(
  parameter int ADDR_W = 31,
  parameter int DATA_W = 512,
  parameter int MAX_RD = 16,
  localparam int MASK_W = DATA_W / 8,
  localparam int CNT_W  = $clog2(MAX_RD) + 1
) (
  input  logic              ui_clk,
  input  logic              ui_rst_n,
  input  logic              init_calib_complete,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wbe,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [MASK_W-1:0] app_wdf_mask,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]  rd_outstanding,
  output logic              err_rd_unexp
);

  localparam logic       ST_IDLE  = 1'b0;
  localparam logic       ST_ISSUE = 1'b1;
  localparam logic [2:0] CMD_WR   = 3'b000;
  localparam logic [2:0] CMD_RD   = 3'b001;
  localparam logic [CNT_W-1:0] MAX_RD_C = CNT_W'(MAX_RD);

  logic              r_state;
  logic              r_ready_en;  // holds req_ready low for the first cycle after reset release
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_mask;
  logic              r_app_en;
  logic              r_wren;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic              r_err;

  logic              w_accept;
  logic              w_rd_issue;
  logic              w_cmd_done;
  logic              w_wdf_done;
  logic [CNT_W-1:0]  w_rd_cnt_d;
  logic              w_err_set;

  // Writes are never throttled by the read cap.
  assign req_ready  = (r_state == ST_IDLE) && r_ready_en && init_calib_complete &&
                      (req_wr || (r_rd_cnt < MAX_RD_C));
  assign w_accept   = req_valid && req_ready;
  assign w_rd_issue = r_app_en && app_rdy && !r_wr;
  // A half is done if it already completed or completes on this edge.
  assign w_cmd_done = !r_app_en || app_rdy;
  assign w_wdf_done = !r_wren || app_wdf_rdy;

  // Simultaneous issue and return cancel out; a return with nothing outstanding is an error
  // and must not wrap the counter.
  always_comb begin
    w_rd_cnt_d = r_rd_cnt;
    w_err_set  = 1'b0;
    if (w_rd_issue && !app_rd_data_valid) begin
      w_rd_cnt_d = r_rd_cnt + 1'b1;
    end else if (!w_rd_issue && app_rd_data_valid) begin
      if (r_rd_cnt != '0) begin
        w_rd_cnt_d = r_rd_cnt - 1'b1;
      end else begin
        w_err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      r_state    <= ST_IDLE;
      r_ready_en <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_app_en   <= 1'b0;
      r_wren     <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_ISSUE;
            r_wr     <= req_wr;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_mask   <= ~req_wbe;
            r_app_en <= 1'b1;
            r_wren   <= req_wr;
          end
        end
        default: begin
          if (app_rdy)     r_app_en <= 1'b0;
          if (app_wdf_rdy) r_wren   <= 1'b0;
          if (w_cmd_done && w_wdf_done) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rd_cnt    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= app_rd_data_valid;
      if (app_rd_data_valid) r_rsp_data <= app_rd_data;
      r_rd_cnt    <= w_rd_cnt_d;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign app_en         = r_app_en;
  assign app_cmd        = r_wr ? CMD_WR : CMD_RD;
  assign app_addr       = r_addr;
  assign app_wdf_wren   = r_wren;
  assign app_wdf_end    = r_wren;
  assign app_wdf_data   = r_wdata;
  assign app_wdf_mask   = r_mask;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rd_outstanding = r_rd_cnt;
  assign err_rd_unexp   = r_err;

endmodule

// File: tb/tb_ddr4_app_req_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_ddr4_app_req_sequencer
// Directed bench: write with both channels ready, write with data ahead of command, read cap
// and drain, simultaneous read issue/return, unexpected read data, calibration gating, and
// reset during an in-flight command.
// ---------------------------------------------------------------------------------------------
module tb_ddr4_app_req_sequencer;

  localparam int ADDR_W = 31;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;
  localparam int MAX_RD = 4;
  localparam int CNT_W  = $clog2(MAX_RD) + 1;

  logic              ui_clk = 1'b0;
  logic              ui_rst_n;
  logic              init_calib_complete;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wbe;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [CNT_W-1:0]  rd_outstanding;
  logic              err_rd_unexp;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cmd    = 0;

  always #5 ui_clk = ~ui_clk;

  ddr4_app_req_sequencer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_RD(MAX_RD)
  ) u_dut (
    .ui_clk              (ui_clk),
    .ui_rst_n            (ui_rst_n),
    .init_calib_complete (init_calib_complete),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_wr              (req_wr),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .req_wbe             (req_wbe),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rd_outstanding      (rd_outstanding),
    .err_rd_unexp        (err_rd_unexp)
  );

  // Count MIG command handshakes as the MIG would see them.
  always @(posedge ui_clk) begin
    if (ui_rst_n && app_en && app_rdy) n_cmd <= n_cmd + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks follow 1 ns later.
  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic rd_pulse(input logic [DATA_W-1:0] d);
    app_rd_data_valid = 1'b1;
    app_rd_data       = d;
    tick();
    app_rd_data_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cmd0;
    ui_rst_n            = 1'b0;
    init_calib_complete = 1'b1;
    req_valid           = 1'b0;
    req_wr              = 1'b0;
    req_addr            = '0;
    req_wdata           = '0;
    req_wbe             = '0;
    app_rdy             = 1'b1;
    app_wdf_rdy         = 1'b1;
    app_rd_data         = '0;
    app_rd_data_valid   = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_app_en", app_en, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_cnt", rd_outstanding, 0);
    chk("rst_err", err_rd_unexp, 0);
    chk("rst_rsp", rsp_valid, 0);
    tick(); tick();
    ui_rst_n = 1'b1;
    #1;
    chk("post_rel_ready", req_ready, 0);
    tick();
    chk("ready_up", req_ready, 1);

    // Write, both channels ready.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 31'h100;
    req_wdata = 64'hA5A5_1234_5678_9ABC; req_wbe = 8'hFF;
    #1 chk("w1_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("w1_app_en", app_en, 1);
    chk("w1_wren", app_wdf_wren, 1);
    chk("w1_end", app_wdf_end, 1);
    chk("w1_cmd", app_cmd, 3'b000);
    chk("w1_addr", app_addr, 31'h100);
    chk("w1_mask", app_wdf_mask, 8'h00);
    chk("w1_data", app_wdf_data, 64'hA5A5_1234_5678_9ABC);
    chk("w1_busy", req_ready, 0);
    tick();
    chk("w1_en_off", app_en, 0);
    chk("w1_wren_off", app_wdf_wren, 0);
    chk("w1_ready_back", req_ready, 1);

    // Write, data channel ready three cycles before the command channel.
    app_rdy = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 31'h200;
    req_wdata = 64'h0BAD_F00D_DEAD_BEEF; req_wbe = 8'h0F;
    tick();
    req_valid = 1'b0;
    cmd0 = n_cmd;
    #1 chk("w2_wren", app_wdf_wren, 1);
    tick();
    chk("w2_wren_off", app_wdf_wren, 0);
    chk("w2_end_off", app_wdf_end, 0);
    for (int i = 0; i < 2; i++) begin
      chk("w2_en_held", app_en, 1);
      chk("w2_addr", app_addr, 31'h200);
      chk("w2_mask", app_wdf_mask, 8'hF0);
      chk("w2_data", app_wdf_data, 64'h0BAD_F00D_DEAD_BEEF);
      chk("w2_busy", req_ready, 0);
      tick();
    end
    chk("w2_en_held3", app_en, 1);
    app_rdy = 1'b1;
    tick();
    chk("w2_en_off", app_en, 0);
    chk("w2_one_cmd", n_cmd - cmd0, 1);
    chk("w2_ready_back", req_ready, 1);

    // Four reads fill the outstanding cap.
    for (int i = 0; i < MAX_RD; i++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 31'(32'h400 + i);
      tick();
      req_valid = 1'b0;
      #1 chk("rd_cmd", app_cmd, 3'b001);
      tick();
    end
    chk("rd_cnt_full", rd_outstanding, 4);
    req_valid = 1'b1; req_wr = 1'b0;
    #1 chk("rd_blocked", req_ready, 0);
    req_wr = 1'b1;
    #1 chk("wr_not_blocked", req_ready, 1);
    req_wr = 1'b0;
    #1;
    rd_pulse(64'h1111_2222_3333_4444);
    chk("rd_cnt_3", rd_outstanding, 3);
    chk("rsp_valid1", rsp_valid, 1);
    chk("rsp_data1", rsp_data, 64'h1111_2222_3333_4444);
    chk("rd_unblocked", req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("rd_cnt_4b", rd_outstanding, 4);
    rd_pulse(64'h1);
    rd_pulse(64'h2);
    chk("rd_cnt_2", rd_outstanding, 2);

    // Read issue coincides with read return.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 31'h500;
    tick();
    req_valid = 1'b0;
    rd_pulse(64'hCAFE_0000_BABE_0001);
    chk("same_cyc_cnt", rd_outstanding, 2);
    chk("same_cyc_rsp", rsp_valid, 1);
    chk("same_cyc_data", rsp_data, 64'hCAFE_0000_BABE_0001);
    rd_pulse(64'h3);
    rd_pulse(64'h4);
    chk("rd_cnt_0", rd_outstanding, 0);
    chk("no_err_yet", err_rd_unexp, 0);

    // Unexpected read data.
    rd_pulse(64'h5);
    chk("err_set", err_rd_unexp, 1);
    chk("err_cnt0", rd_outstanding, 0);
    tick();
    chk("err_sticky", err_rd_unexp, 1);

    // Calibration loss blocks acceptance but not an operation in flight.
    init_calib_complete = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1;
    #1 chk("calib_block", req_ready, 0);
    init_calib_complete = 1'b1;
    app_rdy = 1'b0;
    tick();
    req_valid = 1'b0;
    init_calib_complete = 1'b0;
    tick();
    chk("calib_inflight", app_en, 1);
    app_rdy = 1'b1;
    tick();
    chk("calib_done", app_en, 0);
    init_calib_complete = 1'b1;
    tick();

    // Reset while a read command is stalled, with one read already outstanding.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 31'h600;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_cnt", rd_outstanding, 1);
    app_rdy = 1'b0;
    req_valid = 1'b1; req_addr = 31'h700;
    tick();
    req_valid = 1'b0;
    #1 chk("stall_en", app_en, 1);
    ui_rst_n = 1'b0;
    #1;
    chk("arst_en", app_en, 0);
    chk("arst_wren", app_wdf_wren, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_cnt", rd_outstanding, 0);
    chk("arst_err", err_rd_unexp, 0);
    chk("arst_addr", app_addr, 0);
    tick();
    app_rdy = 1'b1;
    ui_rst_n = 1'b1;
    #1;
    chk("rel_en", app_en, 0);
    chk("rel_ready", req_ready, 0);
    tick();
    chk("rel_en2", app_en, 0);
    chk("rel_cnt", rd_outstanding, 0);
    chk("rel_ready2", req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
